// File: rtl/conv_pkg.sv
// Shared sizing for the conv_8_4 -> conv_out_reduce datapath.
package conv_pkg;

  // conv_8_4 geometry: N input taps window, M-tap kernel
  localparam int unsigned CONV_N     = 8;
  localparam int unsigned CONV_M     = 4;

  // Number of y values produced per frame by conv_8_4
  localparam int unsigned CONV_FRAME = CONV_N - CONV_M + 1;

  // Signed width of each y value and of an exact frame sum
  localparam int unsigned CONV_W_IN  = 18;
  localparam int unsigned CONV_W_SUM = CONV_W_IN + $clog2(CONV_FRAME);

endpackage : conv_pkg

// File: rtl/conv_out_reduce.sv
// Reduces each frame of FRAME signed y samples to its exact sum and signed max,
// presented on a valid/ready output register that holds one result.
module conv_out_reduce
  import conv_pkg::*;
#(
  parameter int unsigned FRAME = CONV_FRAME,
  parameter int unsigned W_IN  = CONV_W_IN,
  parameter int unsigned W_SUM = CONV_W_SUM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W_IN-1:0]  s_data_in_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
  output logic [W_SUM-1:0] m_data_out_sum,
  output logic [W_IN-1:0]  m_data_out_max,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int unsigned     CNT_W    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [W_SUM-1:0] acc_sum_q, acc_sum_d;
  logic signed [W_IN-1:0]  acc_max_q, acc_max_d;
  logic signed [W_SUM-1:0] sum_q, sum_d;
  logic signed [W_IN-1:0]  max_q, max_d;
  logic                    valid_q, valid_d;

  logic signed [W_IN-1:0]  sample;
  logic signed [W_SUM-1:0] frame_sum;
  logic signed [W_IN-1:0]  frame_max;
  logic                    at_last;
  logic                    in_fire;
  logic                    out_fire;

  assign sample = s_data_in_y;

  // Only the frame-completing sample can stall, and only when the held result is not leaving
  assign at_last   = (cnt_q == CNT_LAST);
  assign s_ready_y = !(at_last && valid_q && !m_ready);
  assign in_fire   = s_valid_y && s_ready_y;
  assign out_fire  = valid_q && m_ready;

  // Running sum/max including the current sample; first sample of a frame seeds both
  always_comb begin
    frame_sum = W_SUM'(sample);
    frame_max = sample;
    if (cnt_q != '0) begin
      frame_sum = acc_sum_q + W_SUM'(sample);
      frame_max = (sample > acc_max_q) ? sample : acc_max_q;
    end
  end

  // Next-state for counter, accumulators and output register
  always_comb begin
    cnt_d     = cnt_q;
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    sum_d     = sum_q;
    max_d     = max_q;
    valid_d   = valid_q;

    if (out_fire) begin
      valid_d = 1'b0;
    end

    if (in_fire) begin
      acc_sum_d = frame_sum;
      acc_max_d = frame_max;
      if (at_last) begin
        cnt_d   = '0;
        sum_d   = frame_sum;
        max_d   = frame_max;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      acc_sum_q <= '0;
      acc_max_q <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
    end
  end

  assign m_data_out_sum = sum_q;
  assign m_data_out_max = max_q;
  assign m_valid        = valid_q;

endmodule : conv_out_reduce

// File: tb/tb_conv_out_reduce.sv
// Self-checking bench for conv_out_reduce: directed frame table, stall and
// reset sequences, then random valid/ready traffic against a frame-level model.
module tb_conv_out_reduce;

  localparam int FRAME = 5;
  localparam int W_IN  = 18;
  localparam int W_SUM = 21;

  logic             clk;
  logic             reset;
  logic [W_IN-1:0]  s_data_in_y;
  logic             s_valid_y;
  logic             s_ready_y;
  logic [W_SUM-1:0] m_data_out_sum;
  logic [W_IN-1:0]  m_data_out_max;
  logic             m_valid;
  logic             m_ready;

  conv_out_reduce dut (
    .clk            (clk),
    .reset          (reset),
    .s_data_in_y    (s_data_in_y),
    .s_valid_y      (s_valid_y),
    .s_ready_y      (s_ready_y),
    .m_data_out_sum (m_data_out_sum),
    .m_data_out_max (m_data_out_max),
    .m_valid        (m_valid),
    .m_ready        (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s[FRAME];
    int exp_sum;
    int exp_max;
  } vec_t;

  typedef struct {
    int sum;
    int mx;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   part_q[$];
  res_t exp_q[$];
  res_t out_log[$];
  int   n_results = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_sum();
    return int'($signed(m_data_out_sum));
  endfunction

  function automatic int dut_max();
    return int'($signed(m_data_out_max));
  endfunction

  // One cycle: check outputs mid low phase, update the model with this edge's transfers
  task automatic tick(output bit in_fire);
    bit   out_fire;
    bit   exp_valid;
    bit   exp_ready;
    res_t r;
    #2;
    exp_valid = (exp_q.size() > 0);
    exp_ready = !((part_q.size() == FRAME - 1) && exp_valid && !m_ready);
    check("m_valid", int'(m_valid), int'(exp_valid));
    check("s_ready_y", int'(s_ready_y), int'(exp_ready));
    if (m_valid && exp_valid) begin
      check("held_sum", dut_sum(), exp_q[0].sum);
      check("held_max", dut_max(), exp_q[0].mx);
    end
    in_fire  = s_valid_y && s_ready_y;
    out_fire = m_valid && m_ready;
    if (out_fire) begin
      r.sum = dut_sum();
      r.mx  = dut_max();
      out_log.push_back(r);
      n_results++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (in_fire) begin
      part_q.push_back(int'($signed(s_data_in_y)));
      if (part_q.size() == FRAME) begin
        r.sum = 0;
        r.mx  = part_q[0];
        foreach (part_q[i]) begin
          r.sum += part_q[i];
          if (part_q[i] > r.mx) r.mx = part_q[i];
        end
        exp_q.push_back(r);
        part_q.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit f;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  // Offer one sample until accepted; returns cycles spent
  task automatic send_sample(input int v, output int cycles);
    bit f;
    s_valid_y   = 1'b1;
    s_data_in_y = W_IN'(v);
    cycles = 0;
    f = 1'b0;
    while (!f && cycles < 50) begin
      tick(f);
      cycles++;
    end
    if (!f) check("accept_timeout", 0, 1);
    s_valid_y   = 1'b0;
    s_data_in_y = 'x;
  endtask

  // Send one frame with m_ready=1 and compare the single result to the vector
  task automatic run_vec(input vec_t v, input string name);
    int c;
    int base;
    int waited;
    base = n_results;
    m_ready = 1'b1;
    for (int i = 0; i < FRAME; i++) send_sample(v.s[i], c);
    waited = 0;
    while (n_results == base && waited < 20) begin
      idle(1);
      waited++;
    end
    idle(3);
    check({name, "_count"}, n_results - base, 1);
    if (n_results > base) begin
      check({name, "_sum"}, out_log[base].sum, v.exp_sum);
      check({name, "_max"}, out_log[base].mx, v.exp_max);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int   c;
    int   base;
    vec_t v;
    bit   f;

    reset       = 1'b0;
    s_valid_y   = 1'b0;
    s_data_in_y = '0;
    m_ready     = 1'b0;

    vecs[0].s = '{1, 2, 3, 4, 5};                               vecs[0].exp_sum = 15;      vecs[0].exp_max = 5;
    vecs[1].s = '{-131072, -131072, -131072, -131072, -131072}; vecs[1].exp_sum = -655360; vecs[1].exp_max = -131072;
    vecs[2].s = '{131071, 131071, 131071, 131071, 131071};      vecs[2].exp_sum = 655355;  vecs[2].exp_max = 131071;
    vecs[3].s = '{-7, -3, -9, -3, -8};                          vecs[3].exp_sum = -30;     vecs[3].exp_max = -3;

    // Reset state while reset is held
    #3;
    check("rst_valid", int'(m_valid), 0);
    check("rst_sum", dut_sum(), 0);
    check("rst_max", dut_max(), 0);
    check("rst_ready", int'(s_ready_y), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed frame table
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Two back-to-back frames with the consumer stalled
    m_ready = 1'b0;
    base = n_results;
    v.s = '{100, -50, 7, 0, 3};
    for (int i = 0; i < FRAME; i++) begin
      send_sample(v.s[i], c);
      check("stall_a_cycles", c, 1);
    end
    v.s = '{-1, -2, -3, -4, -5};
    for (int i = 0; i < FRAME - 1; i++) begin
      send_sample(v.s[i], c);
      check("stall_b_cycles", c, 1);
    end
    s_valid_y   = 1'b1;
    s_data_in_y = W_IN'(-5);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_ready_low", int'(s_ready_y), 0);
      check("stall_held_sum", dut_sum(), 60);
      #(-2 + 2);
      tick(f);
      check("stall_no_accept", int'(f), 0);
    end
    m_ready = 1'b1;
    send_sample(-5, c);
    check("stall_last_cycles", c, 1);
    idle(4);
    check("stall_count", n_results - base, 2);
    if (n_results - base == 2) begin
      check("stall_a_sum", out_log[base].sum, 60);
      check("stall_a_max", out_log[base].mx, 100);
      check("stall_b_sum", out_log[base + 1].sum, -15);
      check("stall_b_max", out_log[base + 1].mx, -1);
    end

    // Reset mid-frame while a result is held
    m_ready = 1'b0;
    for (int i = 0; i < FRAME; i++) send_sample(1, c);
    for (int i = 0; i < 3; i++) send_sample(9, c);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", int'(m_valid), 0);
    check("async_sum", dut_sum(), 0);
    check("async_max", dut_max(), 0);
    check("async_ready", int'(s_ready_y), 1);
    part_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    v.s = '{10, 20, 30, 40, 50};
    v.exp_sum = 150;
    v.exp_max = 50;
    run_vec(v, "post_reset");

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      s_valid_y   = 1'($urandom_range(0, 3) != 0);
      s_data_in_y = s_valid_y ? W_IN'(int'($urandom_range(0, 262143)) - 131072) : 'x;
      m_ready     = 1'($urandom_range(0, 2) != 0);
      tick(f);
    end
    s_valid_y   = 1'b0;
    s_data_in_y = 'x;
    m_ready     = 1'b1;
    idle(4);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_conv_out_reduce

// File: doc/conv_out_reduce.md
CONV_OUT_REDUCE -- requirements
Module: conv_out_reduce

Interface
REQ-001 SHALL have parameter FRAME, default 5, which is the number of y values per frame (N-M+1 of conv_8_4).
REQ-002 SHALL have parameter W_IN, default 18, which is the signed width of each incoming y value.
REQ-003 SHALL have parameter W_SUM, default 21, which is the signed width of the sum output (W_IN+ceil(log2(FRAME))).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_data_in_y, input, W_IN bits: signed y sample from conv_8_4 m_data_out_y.
REQ-007 SHALL have port s_valid_y, input, 1 bit: input sample valid.
REQ-008 SHALL have port s_ready_y, output, 1 bit: block can accept a sample.
REQ-009 SHALL have port m_data_out_sum, output, W_SUM bits: signed sum of one frame.
REQ-010 SHALL have port m_data_out_max, output, W_IN bits: signed maximum of one frame.
REQ-011 SHALL have port m_valid, output, 1 bit: a frame result is held.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accepts the result.

Function
REQ-013 An input transfer SHALL occur only on a rising edge with s_valid_y=1 and s_ready_y=1; s_data_in_y is ignored (may be X) otherwise.
REQ-014 An output transfer SHALL occur only on a rising edge with m_valid=1 and m_ready=1.
REQ-015 A counter cnt (0..FRAME-1) SHALL count accepted samples within the current frame, incrementing per input transfer and wrapping from FRAME-1 to 0.
REQ-016 When cnt=0, an accepted sample SHALL load acc_sum with the sign-extended sample and acc_max with the sample.
REQ-017 When cnt>0, an accepted sample SHALL add its sign-extended value to acc_sum and replace acc_max if strictly greater (signed compare).
REQ-018 On acceptance at cnt=FRAME-1, the completed sum and max (including that sample) SHALL be written to the output register, and m_valid SHALL be 1 on the following cycle (latency 1 cycle after the last input).
REQ-019 The output register SHALL hold its values stable while m_valid=1 and m_ready=0.
REQ-020 m_valid SHALL clear after an output transfer unless a new frame completes on the same edge, in which case it stays 1 with the new values.
REQ-021 s_ready_y SHALL be 0 only when cnt=FRAME-1, m_valid=1 and m_ready=0; it SHALL be 1 otherwise, giving one sample per cycle throughput.
REQ-022 s_ready_y SHALL have no combinational dependency on s_valid_y.
REQ-023 Sum arithmetic SHALL be exact; W_SUM is sized so no overflow can occur for any FRAME inputs.

Reset
REQ-024 Assertion of reset (low) SHALL immediately force cnt=0, m_valid=0, m_data_out_sum=0, m_data_out_max=0, acc_sum=0, and acc_max=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first sample accepted after release starts a new frame.
REQ-026 s_ready_y SHALL be 1 during and after reset.

Structure
REQ-027 FRAME, W_IN, and W_SUM defaults SHALL live in shared package conv_pkg, alongside conv_8_4's N and M, with FRAME derived as N-M+1.
REQ-028 The block SHALL be a single module with no sub-modules; the accumulator and output register are in-line.

Verification
REQ-029 Send frame {1,2,3,4,5} with m_ready=1: exactly one result, sum=15 and max=5, m_valid one cycle after the 5th transfer.
REQ-030 Send five samples of -131072: sum=-655360 and max=-131072; then five samples of 131071: sum=655355 and max=131071.
REQ-031 Send frame {-7,-3,-9,-3,-8}: max=-3 and sum=-30, confirming max is not seeded with 0.
REQ-032 Hold m_ready=0 over two back-to-back frames: the first result stays stable, s_ready_y drops only at the 5th sample of the second frame, and no data is lost when m_ready rises.
REQ-033 Assert reset after 3 samples of a frame, then send {10,20,30,40,50}: result sum=150 and max=50, with no residue from the partial frame.
REQ-034 Connect conv_8_4 to this block with random valid/ready as in the conv_8_4 bench, for 100000 frames: every result must match a golden per-frame sum/max computed from expected_out.hex.
